// File: rtl/bl_lane_ser8_ctl.sv
// Row sequencer: forwards eight lane streams onto one output in lane order and merges their end tokens.
// Optional completed-row counter enabled by defining BL_SER8_ROWCNT_EN.
module bl_lane_ser8_ctl #(
  parameter int unsigned W    = 16,
  parameter int unsigned CNTW = 16
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [8*W-1:0]  i_d,
  input  logic [7:0]      i_v,
  input  logic [7:0]      i_e,
  output logic [7:0]      i_b,
  output logic [W-1:0]    o_d,
  output logic            o_v,
  output logic            o_e,
  input  logic            o_b,
  output logic            err
`ifdef BL_SER8_ROWCNT_EN
  ,
  output logic [CNTW-1:0] rowcnt
`endif
);

  localparam int unsigned LANES = 8;
  localparam int unsigned PTRW  = 3;

  typedef enum logic {
    ST_RUN,
    ST_EOSW
  } st_t;

  st_t             st, st_nxt;
  logic [PTRW-1:0] ptr, ptr_nxt;
  logic            err_nxt;
  logic            xfer_c;
  logic            fire_c;
  logic [7:0]      drop_c;
  logic [W-1:0]    lane_w [LANES];

  // Split the packed lane bus into per-lane words
  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      lane_w[k] = i_d[k*W +: W];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      st  <= ST_RUN;
      ptr <= '0;
      err <= 1'b0;
    end else begin
      st  <= st_nxt;
      ptr <= ptr_nxt;
      err <= err_nxt;
    end
  end

  // Next-state and handshake decode; nothing is driven while reset is held
  always_comb begin
    st_nxt  = st;
    ptr_nxt = ptr;
    err_nxt = err;
    i_b     = 8'hFF;
    o_v     = 1'b0;
    o_e     = 1'b0;
    o_d     = lane_w[ptr];
    xfer_c  = 1'b0;
    fire_c  = 1'b0;
    drop_c  = 8'h00;
    if (!reset) begin
      unique case (st)
        ST_RUN: begin
          if (i_v[ptr]) begin
            if (i_e[ptr]) begin
              // End token: a token off lane 0 means the row was cut short
              st_nxt  = ST_EOSW;
              ptr_nxt = '0;
              if (ptr != '0) err_nxt = 1'b1;
            end else begin
              o_v      = 1'b1;
              i_b[ptr] = o_b;
              xfer_c   = !o_b;
            end
          end
        end
        ST_EOSW: begin
          if ((&i_v) && (&i_e)) begin
            fire_c = !o_b;
          end else begin
            // Stray data words are swallowed so the end tokens behind them can arrive
            drop_c = i_v & ~i_e;
            i_b    = ~drop_c;
            if (|drop_c) err_nxt = 1'b1;
          end
        end
        default: st_nxt = ST_RUN;
      endcase
    end
    if (xfer_c) ptr_nxt = ptr + PTRW'(1);
    if (fire_c) begin
      o_v     = 1'b1;
      o_e     = 1'b1;
      o_d     = '0;
      i_b     = 8'h00;
      st_nxt  = ST_RUN;
      ptr_nxt = '0;
    end
  end

`ifdef BL_SER8_ROWCNT_EN
  // Counts rows whose lane 7 word was forwarded; an end-of-stream restarts the count
  always_ff @(posedge clock) begin
    if (reset || fire_c) begin
      rowcnt <= '0;
    end else if (xfer_c && (ptr == PTRW'(LANES - 1))) begin
      rowcnt <= rowcnt + CNTW'(1);
    end
  end
`endif

endmodule

// File: tb/tb_bl_lane_ser8_ctl.sv
// Scoreboard bench for bl_lane_ser8_ctl: stimulus queues expected output words, a monitor checks transfers.
module tb_bl_lane_ser8_ctl;

  localparam int unsigned W    = 16;
  localparam int unsigned CNTW = 16;

  logic            clock;
  logic            reset;
  logic [8*W-1:0]  i_d;
  logic [7:0]      i_v;
  logic [7:0]      i_e;
  logic [7:0]      i_b;
  logic [W-1:0]    o_d;
  logic            o_v;
  logic            o_e;
  logic            o_b;
  logic            err;
`ifdef BL_SER8_ROWCNT_EN
  logic [CNTW-1:0] rowcnt;
`endif

  int total;
  int bad;
  logic [W:0] exp_q [$];

  bl_lane_ser8_ctl #(.W(W), .CNTW(CNTW)) dut (
    .clock (clock),
    .reset (reset),
    .i_d   (i_d),
    .i_v   (i_v),
    .i_e   (i_e),
    .i_b   (i_b),
    .o_d   (o_d),
    .o_v   (o_v),
    .o_e   (o_e),
    .o_b   (o_b),
    .err   (err)
`ifdef BL_SER8_ROWCNT_EN
    ,
    .rowcnt(rowcnt)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic push(input logic [W-1:0] d, input logic e);
    exp_q.push_back({e, d});
  endtask

  task automatic push_row(input int first, input int last);
    for (int k = first; k <= last; k++) push(W'(16'h0100 + k), 1'b0);
  endtask

  task automatic drive(input logic [7:0] v, input logic [7:0] e, input logic b);
    i_v = v;
    i_e = e;
    o_b = b;
    #2;
  endtask

  task automatic adv();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_rowcnt(input string name, input int expv);
`ifdef BL_SER8_ROWCNT_EN
    chk(name, 32'(rowcnt), 32'(expv));
`else
    if (expv < 0) $display("rowcnt %s not built", name);
`endif
  endtask

  // Monitor: every accepted output word must match the head of the expected queue
  always @(negedge clock) begin
    if (!reset && o_v && !o_b) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL out_extra: got d=%h e=%b expected nothing at %0t", o_d, o_e, $time);
      end else begin
        logic [W:0] ex;
        ex = exp_q.pop_front();
        if ({o_e, o_d} !== ex) begin
          bad++;
          $display("FAIL out_word: got d=%h e=%b expected d=%h e=%b at %0t",
                   o_d, o_e, ex[W-1:0], ex[W], $time);
        end
      end
    end
  end

  initial begin
    total = 0;
    bad   = 0;
    for (int k = 0; k < 8; k++) i_d[k*W +: W] = W'(16'h0100 + k);
    reset = 1'b1;
    i_v   = 8'h00;
    i_e   = 8'h00;
    o_b   = 1'b0;
    adv();

    // Reset dominates the handshake even with all lanes valid
    drive(8'hFF, 8'h00, 1'b0);
    chk("rst_ib", 32'(i_b), 32'h0000_00FF);
    chk("rst_ov", 32'(o_v), 32'h0);
    adv();
    chk("rst_err", 32'(err), 32'h0);
    chk_rowcnt("rst_rowcnt", 0);
    reset = 1'b0;

    // 1: two full rows streaming
    push_row(0, 7);
    push_row(0, 7);
    for (int c = 0; c < 16; c++) begin
      drive(8'hFF, 8'h00, 1'b0);
      adv();
    end
    chk("t1_err", 32'(err), 32'h0);
    chk_rowcnt("t1_rowcnt", 2);

    // 2: downstream stall with lane 3 at the head
    push_row(0, 7);
    for (int c = 0; c < 3; c++) begin
      drive(8'hFF, 8'h00, 1'b0);
      adv();
    end
    for (int c = 0; c < 3; c++) begin
      drive(8'hFF, 8'h00, 1'b1);
      chk("t2_ov", 32'(o_v), 32'h1);
      chk("t2_od", 32'(o_d), 32'h0000_0103);
      chk("t2_ib", 32'(i_b), 32'h0000_00FF);
      adv();
    end
    for (int c = 0; c < 5; c++) begin
      drive(8'hFF, 8'h00, 1'b0);
      adv();
    end
    chk_rowcnt("t2_rowcnt", 3);

    // 3: lane 5 starves; later lanes must not leak
    push_row(0, 7);
    for (int c = 0; c < 5; c++) begin
      drive(8'hFF, 8'h00, 1'b0);
      adv();
    end
    for (int c = 0; c < 4; c++) begin
      drive(8'hDF, 8'h00, 1'b0);
      chk("t3_ov", 32'(o_v), 32'h0);
      chk("t3_ib", 32'(i_b), 32'h0000_00FF);
      adv();
    end
    for (int c = 0; c < 3; c++) begin
      drive(8'hFF, 8'h00, 1'b0);
      adv();
    end
    chk_rowcnt("t3_rowcnt", 4);

    // 4: clean end of stream behind back-pressure
    drive(8'hFF, 8'hFF, 1'b1);
    chk("t4_ov_run", 32'(o_v), 32'h0);
    adv();
    drive(8'hFF, 8'hFF, 1'b1);
    chk("t4_ib_stall", 32'(i_b), 32'h0000_00FF);
    adv();
    push(W'(0), 1'b1);
    drive(8'hFF, 8'hFF, 1'b0);
    chk("t4_ib_fire", 32'(i_b), 32'h0);
    chk("t4_oe_fire", 32'(o_e), 32'h1);
    adv();
    chk_rowcnt("t4_rowcnt_clr", 0);
    push_row(0, 7);
    drive(8'hFF, 8'h00, 1'b0);
    chk("t4_oe_after", 32'(o_e), 32'h0);
    chk("t4_od_lane0", 32'(o_d), 32'h0000_0100);
    adv();
    for (int c = 0; c < 7; c++) begin
      drive(8'hFF, 8'h00, 1'b0);
      adv();
    end
    chk_rowcnt("t4_rowcnt", 1);
    chk("t4_err", 32'(err), 32'h0);

    // 5: partial row end token, stray data word dropped in EOSW
    push_row(0, 1);
    for (int c = 0; c < 2; c++) begin
      drive(8'hFF, 8'h00, 1'b0);
      adv();
    end
    drive(8'hFF, 8'h04, 1'b0);
    chk("t5_ov_tok", 32'(o_v), 32'h0);
    chk("t5_ib_tok", 32'(i_b), 32'h0000_00FF);
    adv();
    chk("t5_err_set", 32'(err), 32'h1);
    drive(8'hFF, 8'hBF, 1'b0);
    chk("t5_ib_drop", 32'(i_b), 32'h0000_00BF);
    chk("t5_ov_drop", 32'(o_v), 32'h0);
    adv();
    push(W'(0), 1'b1);
    drive(8'hFF, 8'hFF, 1'b0);
    chk("t5_oe_fire", 32'(o_e), 32'h1);
    adv();
    chk("t5_err_sticky", 32'(err), 32'h1);
    chk_rowcnt("t5_rowcnt", 0);

    // 6: reset in the middle of a row
    push_row(0, 3);
    for (int c = 0; c < 4; c++) begin
      drive(8'hFF, 8'h00, 1'b0);
      adv();
    end
    reset = 1'b1;
    drive(8'hFF, 8'h00, 1'b0);
    chk("t6_ib_rst", 32'(i_b), 32'h0000_00FF);
    chk("t6_ov_rst", 32'(o_v), 32'h0);
    adv();
    reset = 1'b0;
    chk("t6_err", 32'(err), 32'h0);
    push_row(0, 7);
    drive(8'hFF, 8'h00, 1'b0);
    chk("t6_od_lane0", 32'(o_d), 32'h0000_0100);
    adv();
    for (int c = 0; c < 7; c++) begin
      drive(8'hFF, 8'h00, 1'b0);
      adv();
    end

    drive(8'h00, 8'h00, 1'b0);
    adv();
    adv();
    chk("q_empty", 32'(exp_q.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
